// File: rtl/conv1x1_pkg.sv
// Shared widths, saturation limit and reset constants for the pointwise scaling stage.
// Build option CONV1X1_PIPE_BYPASS_EN is handled in the top and interface.
package conv1x1_pkg;

  localparam int unsigned DW_DEF   = 16;
  localparam int unsigned CW_DEF   = 16;
  localparam int unsigned FRAC_DEF = 8;
  localparam int unsigned BW_DEF   = 16;
  localparam int unsigned CH_DEF   = 3;

  localparam longint unsigned BIAS_RST = 64'd0;

  // Signed product of a zero-extended pixel and a signed coefficient.
  function automatic int unsigned prod_w(input int unsigned dw, input int unsigned cw);
    return dw + cw + 1;
  endfunction

  // Headroom for product + rounding constant + bias scaled by FRAC.
  function automatic int unsigned sum_w(input int unsigned dw, input int unsigned cw,
                                        input int unsigned bw, input int unsigned frac);
    int unsigned pw;
    int unsigned bs;
    pw = prod_w(dw, cw);
    bs = bw + frac;
    return ((pw > bs) ? pw : bs) + 1;
  endfunction

  function automatic longint unsigned sat_max(input int unsigned dw);
    return (64'd1 << dw) - 64'd1;
  endfunction

  function automatic longint unsigned unity_coef(input int unsigned frac);
    return 64'd1 << frac;
  endfunction

endpackage

// File: rtl/conv1x1_pipe_if.sv
// Pixel stream, back-pressure and shadow-config signals of the pointwise scaling stage.
// CONV1X1_PIPE_BYPASS_EN adds the bypass request line.
interface conv1x1_pipe_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16,
  parameter int unsigned BW = 16,
  parameter int unsigned CH = 3
);
  logic [DW*CH-1:0] Din;
  logic             dataEn;
  logic             sof;
  logic             din_ready;
  logic             cfg_wr;
  logic [CW*CH-1:0] cfg_coef;
  logic [BW*CH-1:0] cfg_bias;
  logic [DW*CH-1:0] Dout;
  logic             DoutEn;
  logic             dout_ready;
`ifdef CONV1X1_PIPE_BYPASS_EN
  logic             bypass;

  modport master (
    output Din, dataEn, sof, cfg_wr, cfg_coef, cfg_bias, dout_ready, bypass,
    input  din_ready, Dout, DoutEn
  );
  modport slave (
    input  Din, dataEn, sof, cfg_wr, cfg_coef, cfg_bias, dout_ready, bypass,
    output din_ready, Dout, DoutEn
  );
`else
  modport master (
    output Din, dataEn, sof, cfg_wr, cfg_coef, cfg_bias, dout_ready,
    input  din_ready, Dout, DoutEn
  );
  modport slave (
    input  Din, dataEn, sof, cfg_wr, cfg_coef, cfg_bias, dout_ready,
    output din_ready, Dout, DoutEn
  );
`endif
endinterface

// File: rtl/conv1x1_lane.sv
// One channel of the 3-stage multiply / round+bias / saturate datapath.
// All stages shift together on i_en; bias and bypass ride alongside the product.
module conv1x1_lane
  import conv1x1_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned CW   = CW_DEF,
  parameter int unsigned FRAC = FRAC_DEF,
  parameter int unsigned BW   = BW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [DW-1:0]        i_din,
  input  logic signed [CW-1:0] i_coef,
  input  logic signed [BW-1:0] i_bias,
  input  logic                 i_bypass,
  output logic [DW-1:0]        o_dout
);
  localparam int unsigned PW = prod_w(DW, CW);
  localparam int unsigned SW = sum_w(DW, CW, BW, FRAC);
  localparam logic signed [SW-1:0] RND       = SW'(64'd1 << (FRAC - 1));
  localparam logic signed [SW-1:0] SAT_MAX_S = SW'(sat_max(DW));

  logic signed [PW-1:0] r_prod;
  logic signed [BW-1:0] r_bias;
  logic                 r_byp1;
  logic                 r_byp2;
  logic [DW-1:0]        r_din1;
  logic [DW-1:0]        r_din2;
  logic signed [SW-1:0] r_sum;
  logic [DW-1:0]        r_dout;

  logic signed [PW-1:0] w_din_s;
  logic signed [PW-1:0] w_coef_s;
  logic signed [PW-1:0] w_prod;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_res;
  logic [DW-1:0]        w_sat;

  always_comb begin
    w_din_s  = PW'($signed({1'b0, i_din}));
    w_coef_s = PW'(i_coef);
    w_prod   = w_din_s * w_coef_s;
    w_sum    = SW'(r_prod) + RND + (SW'(r_bias) <<< FRAC);
    w_res    = r_sum >>> FRAC;
    // Clamp the rescaled result into the unsigned pixel range.
    if (w_res[SW-1]) begin
      w_sat = '0;
    end else if (w_res > SAT_MAX_S) begin
      w_sat = DW'(sat_max(DW));
    end else begin
      w_sat = w_res[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_bias <= '0;
      r_byp1 <= 1'b0;
      r_byp2 <= 1'b0;
      r_din1 <= '0;
      r_din2 <= '0;
      r_sum  <= '0;
      r_dout <= '0;
    end else if (i_en) begin
      r_prod <= w_prod;
      r_bias <= i_bias;
      r_byp1 <= i_bypass;
      r_din1 <= i_din;
      r_sum  <= w_sum;
      r_byp2 <= r_byp1;
      r_din2 <= r_din1;
      r_dout <= r_byp2 ? r_din2 : w_sat;
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/conv1x1_pipe.sv
// Pointwise per-channel scale+bias stage: valid chain, stall, shadow/active coefficient sets.
// Optional CONV1X1_PIPE_BYPASS_EN adds a per-frame pass-through request.
module conv1x1_pipe
  import conv1x1_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned CW   = CW_DEF,
  parameter int unsigned FRAC = FRAC_DEF,
  parameter int unsigned BW   = BW_DEF,
  parameter int unsigned CH   = CH_DEF
) (
  input logic           clk,
  input logic           rst_n,
  conv1x1_pipe_if.slave bus
);
  localparam logic [CW-1:0] COEF_RST = CW'(unity_coef(FRAC));
  localparam logic [BW-1:0] BIAS_ZERO = BW'(BIAS_RST);

  logic [CW*CH-1:0] r_sh_coef;
  logic [BW*CH-1:0] r_sh_bias;
  logic [CW*CH-1:0] r_act_coef;
  logic [BW*CH-1:0] r_act_bias;
  logic             r_v1;
  logic             r_v2;
  logic             r_v3;

  logic             w_stall;
  logic             w_adv;
  logic             w_acc;
  logic             w_sof_acc;
  logic [CW*CH-1:0] w_new_coef;
  logic [BW*CH-1:0] w_new_bias;
  logic [CW*CH-1:0] w_coef;
  logic [BW*CH-1:0] w_bias;
  logic             w_byp;
  logic [DW-1:0]    w_dout [CH];
  logic [DW*CH-1:0] w_dout_flat;

  assign w_stall   = r_v3 & ~bus.dout_ready;
  assign w_adv     = ~w_stall;
  assign w_acc     = bus.dataEn & w_adv;
  assign w_sof_acc = w_acc & bus.sof;

  // A config write coinciding with the sof accept goes straight to that beat.
  assign w_new_coef = bus.cfg_wr ? bus.cfg_coef : r_sh_coef;
  assign w_new_bias = bus.cfg_wr ? bus.cfg_bias : r_sh_bias;
  assign w_coef     = w_sof_acc ? w_new_coef : r_act_coef;
  assign w_bias     = w_sof_acc ? w_new_bias : r_act_bias;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_coef  <= {CH{COEF_RST}};
      r_sh_bias  <= {CH{BIAS_ZERO}};
      r_act_coef <= {CH{COEF_RST}};
      r_act_bias <= {CH{BIAS_ZERO}};
    end else begin
      if (bus.cfg_wr) begin
        r_sh_coef <= bus.cfg_coef;
        r_sh_bias <= bus.cfg_bias;
      end
      if (w_sof_acc) begin
        r_act_coef <= w_new_coef;
        r_act_bias <= w_new_bias;
      end
    end
  end

`ifdef CONV1X1_PIPE_BYPASS_EN
  logic r_act_byp;

  assign w_byp = w_sof_acc ? bus.bypass : r_act_byp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act_byp <= 1'b0;
    end else if (w_sof_acc) begin
      r_act_byp <= bus.bypass;
    end
  end
`else
  assign w_byp = 1'b0;
`endif

  // Valid chain mirrors the lane stages; bubbles advance like beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= w_acc;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    conv1x1_lane #(
      .DW   (DW),
      .CW   (CW),
      .FRAC (FRAC),
      .BW   (BW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (w_adv),
      .i_din    (bus.Din[k*DW +: DW]),
      .i_coef   (w_coef[k*CW +: CW]),
      .i_bias   (w_bias[k*BW +: BW]),
      .i_bypass (w_byp),
      .o_dout   (w_dout[k])
    );
  end

  always_comb begin
    w_dout_flat = '0;
    for (int k = 0; k < CH; k++) begin
      w_dout_flat[k*DW +: DW] = w_dout[k];
    end
  end

  assign bus.Dout      = w_dout_flat;
  assign bus.DoutEn    = r_v3;
  assign bus.din_ready = w_adv;

endmodule
